// File: rtl/pa_pkg.sv
// pa_pkg: shared definitions for the product accumulator.
//   pa_state_t   - frame state (IDLE, ACCUM, HOLD), 2-bit encoding
//   PA_PROD_W    - default product width (matches the 4x4 multiplier output)
//   PA_ACC_W     - default accumulator width
//   PA_MAX_TERMS - default maximum number of terms per frame
package pa_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } pa_state_t;

    localparam int PA_PROD_W    = 8;
    localparam int PA_ACC_W     = 12;
    localparam int PA_MAX_TERMS = 16;

endpackage

// File: rtl/pa_adder.sv
// pa_adder: unsigned ACC_W-bit adder with carry-out.
// Ports:
//   a, b  - ACC_W-bit unsigned operands
//   sum   - (a + b) modulo 2^ACC_W
//   carry - carry out of bit ACC_W-1
module pa_adder #(
    parameter int ACC_W = 12
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             carry
);

    assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/product_accumulator.sv
// product_accumulator: sums a stream of unsigned products into a wider
// accumulator, closing a frame on in_last or after MAX_TERMS terms, and
// presents sum / term count / sticky overflow on an output handshake.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   in_valid, in_ready    - input handshake
//   in_product            - unsigned product term
//   in_last               - closes the frame (sampled on accepted term only)
//   out_valid, out_ready  - output handshake
//   out_sum               - frame sum modulo 2^ACC_W
//   out_count             - number of terms in the frame
//   out_ovf               - a carry out of the accumulator occurred in the frame
module product_accumulator
    import pa_pkg::*;
#(
    parameter int PROD_W    = PA_PROD_W,
    parameter int ACC_W     = PA_ACC_W,
    parameter int MAX_TERMS = PA_MAX_TERMS,
    parameter int CNT_W     = $clog2(MAX_TERMS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    function automatic logic [ACC_W-1:0] zext(input logic [PROD_W-1:0] p);
        return ACC_W'(p);
    endfunction

    pa_state_t        state_q;
    pa_state_t        state_d;
    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;

    logic             accept;
    logic [ACC_W-1:0] term;
    logic [ACC_W-1:0] add_sum;
    logic             add_carry;
    logic [CNT_W-1:0] cnt_next;

    // Handshake outputs decode straight from the state register so that
    // neither in_valid nor out_ready reaches an output combinationally.
    assign in_ready  = (state_q != HOLD);
    assign out_valid = (state_q == HOLD);
    assign accept    = in_valid & in_ready;

    assign term = zext(in_product);

    pa_adder #(
        .ACC_W (ACC_W)
    ) u_adder (
        .a     (acc_q),
        .b     (term),
        .sum   (add_sum),
        .carry (add_carry)
    );

    // First term of a frame restarts the count; otherwise increment.
    assign cnt_next = (state_q == IDLE) ? CNT_W'(1) : cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    if (in_last || (cnt_next == CNT_W'(MAX_TERMS)))
                        state_d = HOLD;
                    else
                        state_d = ACCUM;
                end
            end
            HOLD: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q <= cnt_next;
                if (state_q == IDLE) begin
                    acc_q <= term;
                    ovf_q <= 1'b0;
                end else begin
                    acc_q <= add_sum;
                    ovf_q <= ovf_q | add_carry;
                end
            end
        end
    end

    // Result registers persist after the handshake until the next frame
    // overwrites them on its first accepted term.
    assign out_sum   = acc_q;
    assign out_count = cnt_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
module tb_product_accumulator;

    localparam int MAXT = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] in_product = 8'd0;

    logic        ready_a, valid_a, ovf_a;
    logic [11:0] sum_a;
    logic [4:0]  count_a;
    logic        ready_b, valid_b, ovf_b;
    logic [9:0]  sum_b;
    logic [4:0]  count_b;

    always #5 clk = ~clk;

    product_accumulator u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (ready_a),
        .in_product (in_product),
        .in_last    (in_last),
        .out_valid  (valid_a),
        .out_ready  (out_ready),
        .out_sum    (sum_a),
        .out_count  (count_a),
        .out_ovf    (ovf_a)
    );

    product_accumulator #(
        .ACC_W (10)
    ) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (ready_b),
        .in_product (in_product),
        .in_last    (in_last),
        .out_valid  (valid_b),
        .out_ready  (out_ready),
        .out_sum    (sum_b),
        .out_count  (count_b),
        .out_ovf    (ovf_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference model: the terms of the most recent frame, whether a frame
    // is in progress, and whether a result is being presented.
    bit m_hold = 1'b0;
    bit m_open = 1'b0;
    int frame[$];

    function automatic int frame_total();
        int t = 0;
        foreach (frame[i]) t += frame[i];
        return t;
    endfunction

    // Compare all outputs of both instances with the model, then advance
    // one clock and apply the same cycle to the model.
    task automatic step();
        int  tot;
        bit  s_rst, s_vld, s_last, s_ordy;
        int  s_prod;
        tot = frame_total();
        chk("in_ready_a",  ready_a, !m_hold);
        chk("out_valid_a", valid_a, m_hold);
        chk("out_sum_a",   sum_a,   tot % 4096);
        chk("out_count_a", count_a, frame.size());
        chk("out_ovf_a",   ovf_a,   tot >= 4096);
        chk("in_ready_b",  ready_b, !m_hold);
        chk("out_valid_b", valid_b, m_hold);
        chk("out_sum_b",   sum_b,   tot % 1024);
        chk("out_count_b", count_b, frame.size());
        chk("out_ovf_b",   ovf_b,   tot >= 1024);
        s_rst  = rst;
        s_vld  = in_valid;
        s_last = in_last;
        s_ordy = out_ready;
        s_prod = int'(in_product);
        @(posedge clk);
        #1;
        if (s_rst) begin
            m_hold = 1'b0;
            m_open = 1'b0;
            frame.delete();
        end else if (m_hold) begin
            if (s_ordy) m_hold = 1'b0;
        end else if (s_vld) begin
            if (!m_open) frame.delete();
            frame.push_back(s_prod);
            m_open = 1'b1;
            if (s_last || frame.size() == MAXT) begin
                m_hold = 1'b1;
                m_open = 1'b0;
            end
        end
    endtask

    task automatic send(input int p, input bit last);
        in_valid   = 1'b1;
        in_product = 8'(p);
        in_last    = last;
        step();
        in_valid   = 1'b0;
        in_last    = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        #1;
        // Reset with random inputs
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid   = 1'($urandom);
            in_product = 8'($urandom);
            in_last    = 1'($urandom);
            out_ready  = 1'($urandom);
            step();
        end
        rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        chk("rst_in_ready",  ready_a, 1);
        chk("rst_out_valid", valid_a, 0);
        chk("rst_out_sum",   sum_a,   0);
        chk("rst_out_count", count_a, 0);
        chk("rst_out_ovf",   ovf_a,   0);
        step();

        // Single-term frame
        send(8'hE1, 1'b1);
        chk("single_valid", valid_a, 1);
        chk("single_sum",   sum_a,   225);
        chk("single_count", count_a, 1);
        chk("single_ovf",   ovf_a,   0);
        handshake();

        // Three back-to-back terms
        send(15, 1'b0);
        send(100, 1'b0);
        send(225, 1'b1);
        chk("three_sum",   sum_a,   340);
        chk("three_count", count_a, 3);
        handshake();

        // Limit closure after 16 terms
        for (int i = 0; i < MAXT; i++) begin
            chk("limit_ready", ready_a, 1);
            send(225, 1'b0);
        end
        chk("limit_valid", valid_a, 1);
        chk("limit_sum",   sum_a,   3600);
        chk("limit_count", count_a, 16);
        chk("limit_ovf",   ovf_a,   0);

        // Backpressure in HOLD with a pending term upstream
        in_valid = 1'b1; in_product = 8'd50; in_last = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_ready",  ready_a, 0);
            chk("bp_sum",    sum_a,   3600);
            chk("bp_count",  count_a, 16);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_idle_ready", ready_a, 1);
        step();
        in_valid = 1'b0; in_last = 1'b0;
        chk("bp_pending_valid", valid_a, 1);
        chk("bp_pending_sum",   sum_a,   50);
        chk("bp_pending_count", count_a, 1);
        handshake();

        // Overflow on the 10-bit instance
        for (int i = 0; i < 5; i++) send(225, i == 4);
        chk("ovf_sum_b",   sum_b,   101);
        chk("ovf_flag_b",  ovf_b,   1);
        chk("ovf_count_b", count_b, 5);
        handshake();

        // Reset mid-frame discards the frame
        send(40, 1'b0);
        send(60, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("midrst_valid", valid_a, 0);
            step();
        end
        send(7, 1'b1);
        chk("post_rst_sum",   sum_a,   7);
        chk("post_rst_count", count_a, 1);
        handshake();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 199) == 0);
            in_valid   = ($urandom_range(0, 3) != 0);
            in_product = 8'($urandom);
            in_last    = ($urandom_range(0, 5) == 0);
            out_ready  = ($urandom_range(0, 1) == 0);
            step();
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
